// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads instruction SRAM over req/ack, feeds fetch/decode register.
// Latency: ack at edge N -> inst_valid_out with that word from cycle N+1; zero-wait SRAM sustains one word/cycle.
// Backpressure: one-entry skid absorbs a word landing on a full, unconsumed output; req drops until it drains.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   en, stall                       downstream consume = inst_valid_out & en & !stall
//   branch_taken, branch_target     single-cycle redirect, highest priority
//   inst_mem_req/addr_out/ack/data  SRAM read port; addr held stable while req high until ack
//   inst_valid_out, instruction_out, pc_out   fetched word and its fetch address + PC_STEP
module if_fetch_ctrl #(
    parameter int                       PC_DATA_WIDTH     = 20,
    parameter int                       INSTRUCTION_WIDTH = 32,
    parameter logic [PC_DATA_WIDTH-1:0] RESET_PC          = '0,
    parameter int                       PC_STEP           = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_DATA_WIDTH-1:0]     branch_target,
    output logic                         inst_mem_req,
    output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr_out,
    input  logic                         inst_mem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
    output logic                         inst_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_DATA_WIDTH-1:0]     pc_out
);

    localparam logic [PC_DATA_WIDTH-1:0] STEP = PC_DATA_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_DATA_WIDTH-1:0]       pc_q, pc_d;
    // Address of the read being drained after a redirect; must stay on the bus until its ack.
    logic [PC_DATA_WIDTH-1:0]       drain_addr_q, drain_addr_d;
    logic                           out_vld_q, out_vld_d;
    logic [INSTRUCTION_WIDTH-1:0]   out_inst_q, out_inst_d;
    logic [PC_DATA_WIDTH-1:0]       out_pc_q, out_pc_d;
    logic                           skid_vld_q, skid_vld_d;
    logic [INSTRUCTION_WIDTH-1:0]   skid_inst_q, skid_inst_d;
    logic [PC_DATA_WIDTH-1:0]       skid_pc_q, skid_pc_d;

    logic consume;
    logic ack_ok;
    logic [PC_DATA_WIDTH-1:0] pc_next;

    assign consume = out_vld_q & en & ~stall;
    // Ack only counts while a request is actually on the bus (never in HOLD or reset).
    assign ack_ok  = inst_mem_ack & inst_mem_req;
    assign pc_next = pc_q + STEP;

    assign inst_mem_req      = ~rst & (state_q != HOLD);
    assign inst_mem_addr_out = rst ? RESET_PC :
                               (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign inst_valid_out  = out_vld_q;
    assign instruction_out = out_inst_q;
    assign pc_out          = out_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        out_vld_d    = out_vld_q & ~consume;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (branch_taken) begin
            // Redirect flushes both entries; any same-cycle consume already happened downstream.
            pc_d       = branch_target;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (!ack_ok) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:  state_d = FETCH;
                DRAIN: state_d = ack_ok ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack_ok) begin
                        pc_d = pc_next;
                        if (!out_vld_q || consume) begin
                            out_vld_d  = 1'b1;
                            out_inst_d = inst_mem_data_in;
                            out_pc_d   = pc_next;
                        end else begin
                            skid_vld_d  = 1'b1;
                            skid_inst_d = inst_mem_data_in;
                            skid_pc_d   = pc_next;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        out_vld_d  = skid_vld_q;
                        out_inst_d = skid_inst_q;
                        out_pc_d   = skid_pc_q;
                        skid_vld_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (ack_ok) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            out_vld_q    <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            skid_vld_q   <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            out_vld_q    <= out_vld_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed scenarios then randomized traffic against a queue-based model.
// Latency: inputs applied at negedge, outputs compared 1ns later, model advanced once per rising edge.
// Backpressure: stall/en randomized; model holds up to two buffered words (output + skid).
module tb_if_fetch_ctrl;

    localparam int PW = 20;
    localparam int IW = 32;
    localparam logic [PW-1:0] RST_PC = 20'h00000;

    logic          clk;
    logic          rst;
    logic          en;
    logic          stall;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          inst_mem_req;
    logic [PW-1:0] inst_mem_addr_out;
    logic          inst_mem_ack;
    logic [IW-1:0] inst_mem_data_in;
    logic          inst_valid_out;
    logic [IW-1:0] instruction_out;
    logic [PW-1:0] pc_out;

    if_fetch_ctrl #(
        .PC_DATA_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .RESET_PC(RST_PC), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .inst_mem_req(inst_mem_req), .inst_mem_addr_out(inst_mem_addr_out),
        .inst_mem_ack(inst_mem_ack), .inst_mem_data_in(inst_mem_data_in),
        .inst_valid_out(inst_valid_out), .instruction_out(instruction_out), .pc_out(pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a recognisable tag in the top bits, the address in the bottom.
    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {12'hC0D, a};
    endfunction

    // Reference model: fetched-but-unconsumed words in order; two entries means the
    // controller is holding, a pending drain means a stale read must be absorbed first.
    typedef struct {
        logic [IW-1:0] inst;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t          m_q[$];
    logic [PW-1:0] m_pc;
    logic          m_drain;
    logic [PW-1:0] m_drain_addr;
    logic [IW-1:0] m_last_inst;
    logic [PW-1:0] m_last_pc;

    function automatic logic [PW-1:0] model_addr(input logic r);
        if (r) return RST_PC;
        return m_drain ? m_drain_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc         = RST_PC;
        m_drain      = 1'b0;
        m_drain_addr = RST_PC;
        m_last_inst  = '0;
        m_last_pc    = '0;
    endtask

    task automatic model_edge(input logic r, e, s, b, input logic [PW-1:0] t, input logic a);
        bit   fetching;
        bit   cons;
        ent_t w;
        if (r) begin
            model_reset();
            return;
        end
        cons     = (m_q.size() > 0) && e && !s;
        fetching = !m_drain && (m_q.size() < 2);
        if (b) begin
            if (m_drain) begin
                if (a) m_drain = 1'b0;
            end else if (fetching && !a) begin
                m_drain      = 1'b1;
                m_drain_addr = m_pc;
            end
            m_q.delete();
            m_pc = t;
        end else begin
            if (cons) void'(m_q.pop_front());
            if (m_drain) begin
                if (a) m_drain = 1'b0;
            end else if (fetching && a) begin
                w.inst = mem_word(m_pc);
                w.pc   = m_pc + 20'd4;
                m_q.push_back(w);
                m_pc = m_pc + 20'd4;
            end
        end
        if (m_q.size() > 0) begin
            m_last_inst = m_q[0].inst;
            m_last_pc   = m_q[0].pc;
        end
    endtask

    task automatic compare_all(input logic r);
        logic exp_req;
        exp_req = !r && !m_drain ? (m_q.size() < 2) : !r;
        check_val("req",   {31'd0, inst_mem_req},   {31'd0, exp_req});
        check_val("addr",  {12'd0, inst_mem_addr_out}, {12'd0, model_addr(r)});
        check_val("valid", {31'd0, inst_valid_out}, {31'd0, (m_q.size() > 0)});
        check_val("inst",  instruction_out, (m_q.size() > 0) ? m_q[0].inst : m_last_inst);
        check_val("pc",    {12'd0, pc_out}, {12'd0, (m_q.size() > 0) ? m_q[0].pc : m_last_pc});
    endtask

    // One clock cycle: drive at negedge, compare, advance model, wait for the next negedge.
    task automatic step(input logic r, e, s, b, input logic [PW-1:0] t, input logic a);
        rst              = r;
        en               = e;
        stall            = s;
        branch_taken     = b;
        branch_target    = t;
        inst_mem_ack     = a;
        inst_mem_data_in = mem_word(model_addr(r));
        #1;
        compare_all(r);
        model_edge(r, e, s, b, t, a);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = '0; inst_mem_ack = 1'b0; inst_mem_data_in = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state, then zero-wait memory with free-flowing consumer.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
            check_val("seq_pc",   {12'd0, pc_out}, 32'(4 * k));
            check_val("seq_inst", instruction_out, {12'hC0D, 20'(4 * (k - 1))});
        end

        // Three-cycle ack latency at address 0.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check_val("lat_wait_addr", {12'd0, inst_mem_addr_out}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("lat_valid", {31'd0, inst_valid_out}, 32'd1);
        check_val("lat_next_addr", {12'd0, inst_mem_addr_out}, 32'h4);

        // Stall held: output + skid fill, request drops, then release.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        check_val("stall_req", {31'd0, inst_mem_req}, 32'd0);
        check_val("stall_hold_pc", {12'd0, pc_out}, 32'h4);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check_val("stall_skid_pc", {12'd0, pc_out}, 32'h8);
        check_val("stall_resume_addr", {12'd0, inst_mem_addr_out}, 32'h8);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Redirect while the read of 0x10 is outstanding.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 20'h00100, 1'b0);
        check_val("drain_addr", {12'd0, inst_mem_addr_out}, 32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("drain_valid", {31'd0, inst_valid_out}, 32'd0);
        check_val("redirect_addr", {12'd0, inst_mem_addr_out}, 32'h100);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("redirect_pc", {12'd0, pc_out}, 32'h104);

        // Redirect coinciding with ack and a full output, then with a full skid.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 20'h00200, 1'b1);
        check_val("flush_ack_valid", {31'd0, inst_valid_out}, 32'd0);
        check_val("flush_ack_addr", {12'd0, inst_mem_addr_out}, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 20'h00300, 1'b1);
        check_val("flush_skid_valid", {31'd0, inst_valid_out}, 32'd0);
        check_val("flush_skid_addr", {12'd0, inst_mem_addr_out}, 32'h300);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);

        // PC wrap at the top of the address space, then reset mid-wait.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 20'hFFFFC, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("wrap_pc", {12'd0, pc_out}, 32'h0);
        check_val("wrap_addr", {12'd0, inst_mem_addr_out}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("rst_after_pc", {12'd0, pc_out}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_val("rst_restart_pc", {12'd0, pc_out}, 32'h4);

        // Randomized traffic; ack is also thrown at the DUT while req is low.
        for (int i = 0; i < 4000; i++) begin
            logic r, e, s, b, a;
            logic [PW-1:0] t;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 9) < 6);
            t = PW'($urandom);
            if ($urandom_range(0, 7) == 0) t = 20'hFFFF8 | (t & 20'h7);
            step(r, e, s, b, t, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
